// File: rtl/core_seq_pkg.sv
// Shared types and constants for the SwitchMCU phase sequencer.
package core_seq_pkg;

  localparam logic [3:0] PH_FETCH = 4'h0;
  localparam logic [3:0] PH_DEC   = 4'h1;
  localparam logic [3:0] PH_EXE   = 4'h2;
  localparam logic [3:0] PH_MEM   = 4'h3;
  localparam logic [3:0] PH_WB    = 4'h4;
  localparam logic [3:0] PH_ERR   = 4'hE;
  localparam logic [3:0] PH_HALT  = 4'hF;

  localparam int TIMEOUT_W_DEF   = 8;
  localparam int TIMEOUT_MAX_DEF = 255;

  // State encoding equals the phase code, so cycle_cnt is the state itself.
  typedef enum logic [3:0] {
    S_FETCH = PH_FETCH,
    S_DEC   = PH_DEC,
    S_EXE   = PH_EXE,
    S_MEM   = PH_MEM,
    S_WB    = PH_WB,
    S_ERR   = PH_ERR,
    S_HALT  = PH_HALT
  } state_e;

endpackage

// File: rtl/core_seq_swc_timer.sv
// Bus-wait watchdog counter shared by the FETCH and MEM phases.
// expired is high once the counter has reached MAX.
module seq_wait_timer
  import core_seq_pkg::*;
#(
  parameter int W   = TIMEOUT_W_DEF,
  parameter int MAX = TIMEOUT_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic cnt_en,
  output logic expired
);

  localparam logic [W-1:0] MAX_V = MAX[W-1:0];

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (cnt_en)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == MAX_V);

endmodule

// File: rtl/core_seq_swc.sv
// Multi-cycle instruction-phase sequencer with run/halt/step and bus watchdog.
// Optional perf counters are enabled by defining SEQ_PERF_CNT_EN.
module core_seq_swc
  import core_seq_pkg::*;
#(
  parameter int TIMEOUT_W   = TIMEOUT_W_DEF,
  parameter int TIMEOUT_MAX = TIMEOUT_MAX_DEF
) (
  input  logic        hclk,
  input  logic        hrst,
  input  logic        run_en,
  input  logic        step_req,
  input  logic        itcm_hready,
  input  logic        dtcm_hready,
  input  logic        dec_mem_en,
  input  logic        dec_halt,
  output logic [3:0]  cycle_cnt,
  output logic        ifu_dec_stall,
  output logic        halted,
  output logic        bus_err,
  output logic        retire,
  output logic [31:0] instret,
  output logic [31:0] stall_cycles
);

  state_e state_q, state_d;
  logic   step_q, step_d;
  logic   mem_q, mem_d;
  logic   hlt_q, hlt_d;

  logic in_wait;
  logic hready;
  logic wait_lo;
  logic expired;

  assign in_wait = (state_q == S_FETCH) || (state_q == S_MEM);
  assign hready  = (state_q == S_MEM) ? dtcm_hready : itcm_hready;
  assign wait_lo = in_wait && !hready;

  // Held clear outside FETCH/MEM so every phase entry starts at zero.
  seq_wait_timer #(
    .W   (TIMEOUT_W),
    .MAX (TIMEOUT_MAX)
  ) u_timer (
    .clk     (hclk),
    .rst     (hrst),
    .clr     (!in_wait),
    .cnt_en  (wait_lo),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    mem_d   = mem_q;
    hlt_d   = hlt_q;
    case (state_q)
      S_HALT: begin
        if (run_en) begin
          state_d = S_FETCH;
          step_d  = 1'b0;
        end else if (step_req) begin
          state_d = S_FETCH;
          step_d  = 1'b1;
        end
      end
      S_FETCH: begin
        if (itcm_hready)
          state_d = S_DEC;
        else if (expired)
          state_d = S_ERR;
      end
      S_DEC: begin
        state_d = S_EXE;
        mem_d   = dec_mem_en;
        hlt_d   = dec_halt;
      end
      S_EXE: state_d = mem_q ? S_MEM : S_WB;
      S_MEM: begin
        if (dtcm_hready)
          state_d = S_WB;
        else if (expired)
          state_d = S_ERR;
      end
      S_WB: begin
        if (hlt_q || step_q || !run_en)
          state_d = S_HALT;
        else
          state_d = S_FETCH;
        step_d = 1'b0;
        mem_d  = 1'b0;
        hlt_d  = 1'b0;
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hrst) begin
      state_q <= S_HALT;
      step_q  <= 1'b0;
      mem_q   <= 1'b0;
      hlt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      mem_q   <= mem_d;
      hlt_q   <= hlt_d;
    end
  end

  assign cycle_cnt     = state_q;
  assign halted        = (state_q == S_HALT);
  assign bus_err       = (state_q == S_ERR);
  assign retire        = (state_q == S_WB);
  assign ifu_dec_stall = halted || bus_err || wait_lo;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] instret_q, instret_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    instret_d = instret_q + {31'd0, retire};
    stall_d   = stall_q + {31'd0, wait_lo};
  end

  always_ff @(posedge hclk) begin
    if (hrst) begin
      instret_q <= '0;
      stall_q   <= '0;
    end else begin
      instret_q <= instret_d;
      stall_q   <= stall_d;
    end
  end

  assign instret      = instret_q;
  assign stall_cycles = stall_q;
`else
  assign instret      = '0;
  assign stall_cycles = '0;
`endif

endmodule
